// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_stream_pkg;

   // Number of words the output buffer can hold.
   localparam int BUF_DEPTH = 2;

   // Output buffer occupancy.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } occ_state_e;

endpackage

// File: rtl/fifo_rd_stream_skid_buf_2.sv
// Two-entry in-order data/last buffer: the head entry drives the output and the skid entry is behind it.
// Latency: a pushed word is visible at the head output the cycle after the push edge, when the buffer was empty.
// Backpressure: pop is driven by the consumer; the producer must never push while two entries are held.
module skid_buf_2
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             push_last_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             head_last_o,
   output logic             skid_last_o,
   output logic [1:0]       occ_o
);

   occ_state_e       state_q, state_d;
   logic [WIDTH-1:0] head_dat_q, head_dat_d;
   logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic             head_last_q, head_last_d;
   logic             skid_last_q, skid_last_d;

   // Occupancy state and both storage entries; reset discards everything held.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_EMPTY;
         head_dat_q  <= '0;
         skid_dat_q  <= '0;
         head_last_q <= 1'b0;
         skid_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_dat_q  <= head_dat_d;
         skid_dat_q  <= skid_dat_d;
         head_last_q <= head_last_d;
         skid_last_q <= skid_last_d;
      end
   end

   // Next occupancy and entry movement; the head only changes on a pop or when filling an empty buffer.
   always_comb begin
      state_d     = state_q;
      head_dat_d  = head_dat_q;
      skid_dat_d  = skid_dat_q;
      head_last_d = head_last_q;
      skid_last_d = skid_last_q;
      case (state_q)
         S_EMPTY: begin
            if (push_i) begin
               head_dat_d  = push_dat_i;
               head_last_d = push_last_i;
               state_d     = S_ONE;
            end
         end
         S_ONE: begin
            case ({push_i, pop_i})
               2'b10: begin
                  skid_dat_d  = push_dat_i;
                  skid_last_d = push_last_i;
                  state_d     = S_TWO;
               end
               2'b01: state_d = S_EMPTY;
               2'b11: begin
                  head_dat_d  = push_dat_i;
                  head_last_d = push_last_i;
               end
               default: ;
            endcase
         end
         S_TWO: begin
            if (pop_i) begin
               head_dat_d  = skid_dat_q;
               head_last_d = skid_last_q;
               if (push_i) begin
                  skid_dat_d  = push_dat_i;
                  skid_last_d = push_last_i;
               end else begin
                  state_d = S_ONE;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   assign head_dat_o  = head_dat_q;
   assign head_last_o = head_last_q;
   assign skid_last_o = skid_last_q;
   assign occ_o       = state_q;

   // The upstream credit scheme must make a push into a full buffer impossible.
   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push_i && (state_q == S_TWO)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a standard-mode (non-FWFT) FIFO onto a valid/ready stream at up to one word per clock; optional packet Last via FIFO_RD_STREAM_LAST_EN.
// Latency: 2 cycles from FIFO non-empty to o_Tx_Valid with an empty buffer (read strobe, then capture).
// Backpressure: read enables are credit-limited so at most 2 words are buffered or in flight; reading restarts in the same cycle as the freeing pop.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
)
(
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   output logic             o_Fifo_Rd_En,
   input  logic             i_Fifo_Rd_DV,
   input  logic [WIDTH-1:0] i_Fifo_Rd_Data,
   input  logic             i_Fifo_Empty,
   output logic             o_Tx_Valid,
   output logic [WIDTH-1:0] o_Tx_Data,
   input  logic             i_Tx_Ready,
   output logic             o_Tx_Last,
   input  logic [LEN_W-1:0] i_Pkt_Len,
   output logic             o_Idle
);

   logic [1:0] occ;
   logic       infl_q;
   logic       pop;
   logic       push;
   logic       push_last;
   logic       head_last;
   logic       skid_last;
   logic [2:0] credit;

   assign pop  = o_Tx_Valid & i_Tx_Ready;
   // A data strobe only counts when a read was actually issued after reset.
   assign push = i_Fifo_Rd_DV & infl_q;

   // Words held plus the word in flight must stay below the buffer depth after this cycle's pop.
   assign credit       = {1'b0, occ} + {2'b00, infl_q};
   assign o_Fifo_Rd_En = i_Rst_L & ~i_Fifo_Empty &
                         (credit < (3'(BUF_DEPTH) + {2'b00, pop}));

   assign o_Tx_Valid = (occ != 2'd0);
   assign o_Idle     = (occ == 2'd0) & ~infl_q;

   // Track the read issued last cycle; its data arrives this cycle.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) infl_q <= 1'b0;
      else          infl_q <= o_Fifo_Rd_En;
   end

`ifdef FIFO_RD_STREAM_LAST_EN
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] pos;
   logic [LEN_W-1:0] len_eff;
   logic             word_ahead;
   logic             ahead_last;

   // Popped-word counter and the length latched at the start of the packet being filled.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   // Packet position of the word entering the buffer: popped count plus any word still held ahead of it.
   always_comb begin
      cnt_d = cnt_q;
      if (pop) cnt_d = head_last ? '0 : cnt_q + LEN_W'(1);
      word_ahead = ((occ == 2'd2) & pop) | ((occ == 2'd1) & ~pop);
      ahead_last = pop ? skid_last : head_last;
      if (!word_ahead)     pos = cnt_d;
      else if (ahead_last) pos = '0;
      else                 pos = cnt_d + LEN_W'(1);
      if (pos == '0) len_eff = (i_Pkt_Len == '0) ? LEN_W'(1) : i_Pkt_Len;
      else           len_eff = len_q;
      push_last = (pos == (len_eff - LEN_W'(1)));
      len_d     = (push && (pos == '0)) ? len_eff : len_q;
   end

   assign o_Tx_Last = head_last;
`else
   logic unused_pkt;
   assign push_last  = 1'b0;
   assign o_Tx_Last  = 1'b0;
   assign unused_pkt = ^{i_Pkt_Len, head_last, skid_last};
`endif

   skid_buf_2 #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk_i       (i_Clk),
      .rst_n_i     (i_Rst_L),
      .push_i      (push),
      .push_dat_i  (i_Fifo_Rd_Data),
      .push_last_i (push_last),
      .pop_i       (pop),
      .head_dat_o  (o_Tx_Data),
      .head_last_o (head_last),
      .skid_last_o (skid_last),
      .occ_o       (occ)
   );

   // The credit gate must never strobe an empty FIFO.
   a_no_read_empty: assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
      !(o_Fifo_Rd_En && i_Fifo_Empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural non-FWFT FIFO, scoreboard of written words, per-scenario tasks.
// Latency: checks the 2-cycle first-word latency and 1 word/clock streaming.
// Backpressure: checks the 2-read credit limit, output stability under stall and restart.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd_en;
   logic       fdv = 1'b0;
   logic [7:0] fdata = 8'h00;
   logic       fempty = 1'b1;
   logic       hold = 1'b0;
   logic       inj_dv = 1'b0;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       valid;
   logic [7:0] data;
   logic       ready = 1'b0;
   logic       last;
   logic [7:0] pkt_len = 8'd0;
   logic       idle;
   logic       dut_empty;
   logic       dut_dv;

   int n_checks = 0;
   int n_pass = 0;
   int pop_cnt = 0;
   int last_cnt = 0;
   int rd_empty_err = 0;

   logic [7:0] fifo_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] mpos = 8'd0;
   logic [7:0] mlen = 8'd1;

   logic       prev_stall = 1'b0;
   logic [7:0] prev_dat = 8'h00;
   logic       prev_last = 1'b0;

   assign dut_empty = fempty | hold;
   assign dut_dv    = fdv | inj_dv;

   always #5 clk = ~clk;

   fifo_rd_stream #(.WIDTH(8), .LEN_W(8)) dut (
      .i_Clk          (clk),
      .i_Rst_L        (rst_n),
      .o_Fifo_Rd_En   (rd_en),
      .i_Fifo_Rd_DV   (dut_dv),
      .i_Fifo_Rd_Data (fdata),
      .i_Fifo_Empty   (dut_empty),
      .o_Tx_Valid     (valid),
      .o_Tx_Data      (data),
      .i_Tx_Ready     (ready),
      .o_Tx_Last      (last),
      .i_Pkt_Len      (pkt_len),
      .o_Idle         (idle)
   );

   // Behavioural FIFO: registered read data one cycle after the strobe, registered empty flag.
   always @(posedge clk) begin
      if (flush) begin
         fifo_q.delete();
      end else begin
         if (rd_en) begin
            if (fifo_q.size() != 0) fdata <= fifo_q.pop_front();
            else rd_empty_err++;
         end
         if (wr_en) fifo_q.push_back(wr_data);
      end
      fdv    <= rd_en;
      fempty <= (fifo_q.size() == 0);
   end

   // Output monitor: scoreboard compare on handshake, stability under stall, no strobe while empty.
   always @(negedge clk) begin
      logic [8:0] exp;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            if (!valid || data !== prev_dat || last !== prev_last)
               $display("FAIL stall_stable: got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                        valid, data, last, prev_dat, prev_last);
            else n_pass++;
         end
         if (valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL stream_word: got data=%h last=%b want no word", data, last);
            end else begin
               exp = exp_q.pop_front();
               if ({last, data} !== exp)
                  $display("FAIL stream_word: got data=%h last=%b want data=%h last=%b",
                           data, last, exp[7:0], exp[8]);
               else n_pass++;
            end
            pop_cnt++;
            if (last) last_cnt++;
         end
         if (rd_en) begin
            n_checks++;
            if (dut_empty) $display("FAIL rd_while_empty: got rd_en=1 want 0");
            else n_pass++;
         end
         prev_stall = valid && !ready;
         prev_dat   = data;
         prev_last  = last;
      end
   end

   // Watchdog so the bench always ends.
   initial begin
      #500000;
      $display("FAIL timeout: got still running want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo_write(input logic [7:0] w);
      logic lst;
`ifdef FIFO_RD_STREAM_LAST_EN
      if (mpos == 8'd0) mlen = (pkt_len == 8'd0) ? 8'd1 : pkt_len;
      lst  = (mpos == mlen - 8'd1);
      mpos = lst ? 8'd0 : mpos + 8'd1;
`else
      lst = 1'b0;
`endif
      exp_q.push_back({lst, w});
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      tick();
      fifo_write(8'hC3);
      fifo_write(8'h3C);
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
      n_checks++; if (rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", rd_en); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
      n_checks++; if (last !== 1'b0) $display("FAIL rst_last: got %b want 0", last); else n_pass++;
      n_checks++; if (data !== 8'h00) $display("FAIL rst_data: got %h want 00", data); else n_pass++;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      mpos = 8'd0;
      tick();
      rst_n  = 1'b1;
      inj_dv = 1'b1;
      tick();
      inj_dv = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen = seen | valid;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL stray_dv: got valid=%b want 0", seen); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL post_rst_idle: got %b want 1", idle); else n_pass++;
      tick();
   endtask

   task automatic test_streaming();
      logic [7:0] rd_bits;
      logic [7:0] v_bits;
      ready = 1'b1;
      hold  = 1'b1;
      fifo_write(8'h11);
      fifo_write(8'h22);
      fifo_write(8'h33);
      fifo_write(8'h44);
      tick();
      hold = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rd_bits[i] = rd_en;
         v_bits[i]  = valid;
      end
      n_checks++; if (rd_bits !== 8'b0000_1111) $display("FAIL stream_rd_en: got %b want 00001111", rd_bits); else n_pass++;
      n_checks++; if (v_bits !== 8'b0011_1100) $display("FAIL stream_valid: got %b want 00111100", v_bits); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL stream_idle: got %b want 1", idle); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL stream_drained: got %0d left want 0", exp_q.size()); else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      int rd_n;
      int gaps;
      int p0;
      ready = 1'b0;
      hold  = 1'b1;
      fifo_write(8'h11);
      fifo_write(8'h22);
      fifo_write(8'h33);
      fifo_write(8'h44);
      fifo_write(8'h55);
      fifo_write(8'h66);
      tick();
      hold = 1'b0;
      rd_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rd_n += int'(rd_en);
      end
      n_checks++; if (rd_n != 2) $display("FAIL bp_reads: got %0d want 2", rd_n); else n_pass++;
      n_checks++; if (valid !== 1'b1 || data !== 8'h11) $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=11", valid, data); else n_pass++;
      tick();
      ready = 1'b1;
      p0    = pop_cnt;
      gaps  = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (!valid) gaps++;
      end
      tick();
      n_checks++; if (gaps != 0) $display("FAIL bp_gaps: got %0d want 0", gaps); else n_pass++;
      n_checks++; if (pop_cnt - p0 != 6) $display("FAIL bp_pops: got %0d want 6", pop_cnt - p0); else n_pass++;
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL bp_done: got valid=%b want 0", valid); else n_pass++;
      tick();
   endtask

   task automatic test_empty_midstream();
      int p0;
      int e0;
      ready = 1'b1;
      p0 = pop_cnt;
      e0 = rd_empty_err;
      fifo_write(8'h77);
      repeat (5) tick();
      fifo_write(8'h88);
      repeat (6) tick();
      n_checks++; if (pop_cnt - p0 != 2) $display("FAIL mid_pops: got %0d want 2", pop_cnt - p0); else n_pass++;
      n_checks++; if (rd_empty_err != e0) $display("FAIL mid_empty_read: got %0d want %0d", rd_empty_err, e0); else n_pass++;
   endtask

`ifdef FIFO_RD_STREAM_LAST_EN
   task automatic test_packet();
      int l0;
      ready   = 1'b1;
      pkt_len = 8'd3;
      l0 = last_cnt;
      for (int i = 0; i < 7; i++) fifo_write(8'h30 + 8'(i));
      repeat (6) tick();
      n_checks++; if (last_cnt - l0 != 2) $display("FAIL pkt_len3_lasts: got %0d want 2", last_cnt - l0); else n_pass++;
      fifo_write(8'h37);
      fifo_write(8'h38);
      repeat (6) tick();
      pkt_len = 8'd0;
      l0 = last_cnt;
      fifo_write(8'h40);
      fifo_write(8'h41);
      fifo_write(8'h42);
      repeat (6) tick();
      n_checks++; if (last_cnt - l0 != 3) $display("FAIL pkt_len0_lasts: got %0d want 3", last_cnt - l0); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      logic seen;
      int   p0;
      ready = 1'b0;
      fifo_write(8'hB1);
      fifo_write(8'hB2);
      fifo_write(8'hB3);
      fifo_write(8'hB4);
      fifo_write(8'hB5);
      repeat (3) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++; if (valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", valid); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL mid_rst_idle: got %b want 1", idle); else n_pass++;
      n_checks++; if (rd_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %b want 0", rd_en); else n_pass++;
      n_checks++; if (data !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", data); else n_pass++;
      n_checks++; if (last !== 1'b0) $display("FAIL mid_rst_last: got %b want 0", last); else n_pass++;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      mpos = 8'd0;
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | valid;
      end
      tick();
      n_checks++; if (seen !== 1'b0) $display("FAIL mid_rst_stale: got valid=%b want 0", seen); else n_pass++;
      ready = 1'b1;
      p0 = pop_cnt;
      fifo_write(8'hA5);
      fifo_write(8'h5A);
      repeat (6) tick();
      n_checks++; if (pop_cnt - p0 != 2) $display("FAIL mid_rst_fresh: got %0d want 2", pop_cnt - p0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_midstream();
`ifdef FIFO_RD_STREAM_LAST_EN
      test_packet();
`endif
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d left want 0", exp_q.size()); else n_pass++;
      n_checks++; if (rd_empty_err != 0) $display("FAIL final_empty_reads: got %0d want 0", rd_empty_err); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
